game_ctrl_fsm: RTL and testbench

//   Parametrised game-flow controller: next generation of the single-life start/play/over FSM.

---
 rtl/game_ctrl_if.sv | 41 ++++
 rtl/game_ctrl_fsm.sv | 153 +++++++++++++++
 tb/tb_game_ctrl_fsm.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/game_ctrl_if.sv
// Signal bundle between input conditioning / renderer and the game-flow controller.
// The master side drives the button and tick inputs; the slave side is the controller.
interface game_ctrl_if #(
  parameter int SCORE_W   = 12,
  parameter int LANE_W    = 2,
  parameter int LIVES     = 3,
  parameter int MAX_LEVEL = 7
);
  localparam int LIVES_W = $clog2(LIVES + 1);
  localparam int LEVEL_W = $clog2(MAX_LEVEL + 1);

  logic               tick_in;
  logic               died_in;
  logic               jump_in;
  logic               pause_in;
  logic [LANE_W-1:0]  lane_in;

  logic               playing;
  logic               paused;
  logic               game_over;
  logic               reset_game;
  logic [SCORE_W-1:0] time_alive;
  logic [SCORE_W-1:0] high_score;
  logic [LIVES_W-1:0] lives_left;
  logic [LEVEL_W-1:0] level;
  logic               invuln;
  logic [LANE_W-1:0]  lane_out;
  logic               jump_out;

  modport master (
    output tick_in, died_in, jump_in, pause_in, lane_in,
    input  playing, paused, game_over, reset_game, time_alive, high_score,
           lives_left, level, invuln, lane_out, jump_out
  );

  modport slave (
    input  tick_in, died_in, jump_in, pause_in, lane_in,
    output playing, paused, game_over, reset_game, time_alive, high_score,
           lives_left, level, invuln, lane_out, jump_out
  );
endinterface

// File: rtl/game_ctrl_fsm.sv
// Game-flow controller: start/play/pause/resume/over sequencing with lives,
// post-hit invulnerability, speed levels, saturating score and retained high score.
module game_ctrl_fsm #(
  parameter int SCORE_W      = 12,
  parameter int LIVES        = 3,
  parameter int LANE_W       = 2,
  parameter int INVULN_TICKS = 8,
  parameter int LEVEL_TICKS  = 256,
  parameter int MAX_LEVEL    = 7,
  parameter int RESUME_TICKS = 3
) (
  input logic        clk_in,
  input logic        rst_n_in,
  game_ctrl_if.slave bus
);
  localparam int LIVES_W = $clog2(LIVES + 1);
  localparam int LEVEL_W = $clog2(MAX_LEVEL + 1);
  localparam int INV_W   = $clog2(INVULN_TICKS + 1);
  localparam int RES_W   = $clog2(RESUME_TICKS + 1);
  localparam int LCNT_W  = (LEVEL_TICKS > 1) ? $clog2(LEVEL_TICKS) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PLAYING  = 3'd1,
    PAUSED   = 3'd2,
    RESUME   = 3'd3,
    GAMEOVER = 3'd4
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               jump_q;
  logic               pause_q;
  logic               jump_rise;
  logic               pause_rise;
  logic               hit;
  logic               hit_fatal;
  logic               tick_apply;
  logic [SCORE_W-1:0] time_alive;
  logic [SCORE_W-1:0] high_score;
  logic [LIVES_W-1:0] lives;
  logic [LEVEL_W-1:0] level;
  logic [LCNT_W-1:0]  level_cnt;
  logic [INV_W-1:0]   invuln_cnt;
  logic [RES_W-1:0]   resume_cnt;
  logic [LANE_W-1:0]  lane_q;
  logic               jump_out_q;

  assign jump_rise  = bus.jump_in & ~jump_q;
  assign pause_rise = bus.pause_in & ~pause_q;
  assign hit        = (state == PLAYING) & bus.died_in & (invuln_cnt == '0);
  assign hit_fatal  = hit & (lives == LIVES_W'(1));
  // A non-fatal hit outranks a pause request, so the tick still counts then.
  assign tick_apply = (state == PLAYING) & bus.tick_in & ~hit_fatal & (hit | ~pause_rise);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (jump_rise) state_next = PLAYING;
      PLAYING: begin
        if (hit_fatal)              state_next = GAMEOVER;
        else if (!hit && pause_rise) state_next = PAUSED;
      end
      PAUSED:   if (pause_rise) state_next = RESUME;
      RESUME: begin
        if (pause_rise)                                   state_next = PAUSED;
        else if (bus.tick_in && resume_cnt <= RES_W'(1)) state_next = PLAYING;
      end
      GAMEOVER: if (jump_rise) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      jump_q     <= 1'b0;
      pause_q    <= 1'b0;
      lane_q     <= '0;
      jump_out_q <= 1'b0;
      time_alive <= '0;
      high_score <= '0;
      lives      <= LIVES_W'(LIVES);
      level      <= '0;
      level_cnt  <= '0;
      invuln_cnt <= '0;
      resume_cnt <= '0;
    end else begin
      jump_q  <= bus.jump_in;
      pause_q <= bus.pause_in;
      if (state == PLAYING) begin
        lane_q     <= bus.lane_in;
        jump_out_q <= bus.jump_in;
      end else begin
        jump_out_q <= 1'b0;
      end

      if (state == IDLE && jump_rise) begin
        time_alive <= '0;
        level      <= '0;
        level_cnt  <= '0;
        invuln_cnt <= '0;
        resume_cnt <= '0;
        lives      <= LIVES_W'(LIVES);
      end

      if (hit_fatal) begin
        lives <= '0;
        if (time_alive > high_score) high_score <= time_alive;
      end else if (hit) begin
        lives <= lives - LIVES_W'(1);
      end

      if (hit && !hit_fatal)
        invuln_cnt <= INV_W'(INVULN_TICKS);
      else if (tick_apply && invuln_cnt != '0)
        invuln_cnt <= invuln_cnt - INV_W'(1);

      if (tick_apply) begin
        if (time_alive != '1) time_alive <= time_alive + SCORE_W'(1);
        if (level_cnt == LCNT_W'(LEVEL_TICKS - 1)) begin
          level_cnt <= '0;
          if (level != LEVEL_W'(MAX_LEVEL)) level <= level + LEVEL_W'(1);
        end else begin
          level_cnt <= level_cnt + LCNT_W'(1);
        end
      end

      if (state == PAUSED && pause_rise)
        resume_cnt <= RES_W'(RESUME_TICKS);
      else if (state == RESUME && !pause_rise && bus.tick_in && resume_cnt != '0)
        resume_cnt <= resume_cnt - RES_W'(1);
    end
  end

  always_comb begin
    bus.playing    = (state == PLAYING);
    bus.paused     = (state == PAUSED) || (state == RESUME);
    bus.game_over  = (state == GAMEOVER);
    bus.reset_game = (state == IDLE);
    bus.time_alive = time_alive;
    bus.high_score = high_score;
    bus.lives_left = lives;
    bus.level      = level;
    bus.invuln     = (invuln_cnt != '0);
    bus.lane_out   = lane_q;
    bus.jump_out   = jump_out_q;
  end
endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Testbench for game_ctrl_fsm with small parameters so saturation, lives and
// countdowns are reached within a few hundred cycles.
module tb_game_ctrl_fsm;
  localparam int SCORE_W      = 4;
  localparam int LIVES        = 3;
  localparam int LANE_W       = 2;
  localparam int INVULN_TICKS = 4;
  localparam int LEVEL_TICKS  = 4;
  localparam int MAX_LEVEL    = 2;
  localparam int RESUME_TICKS = 2;
  localparam int SCORE_MAX    = (1 << SCORE_W) - 1;

  typedef enum int {S_IDLE, S_PLAYING, S_PAUSED, S_RESUME, S_GAMEOVER} modelState_t;

  typedef struct {
    int flags;
    int timeAlive;
    int highScore;
    int lives;
    int level;
    int invuln;
    int lane;
    int jumpOut;
  } expected_t;

  expected_t scoreboard[$];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  modelState_t mState;
  int mTime, mHigh, mLives, mLevel, mLevelCnt, mInv, mRes, mLane;
  bit mJumpOut, mJumpQ, mPauseQ;

  game_ctrl_if #(.SCORE_W(SCORE_W), .LANE_W(LANE_W), .LIVES(LIVES), .MAX_LEVEL(MAX_LEVEL)) bus ();

  game_ctrl_fsm #(
    .SCORE_W(SCORE_W), .LIVES(LIVES), .LANE_W(LANE_W), .INVULN_TICKS(INVULN_TICKS),
    .LEVEL_TICKS(LEVEL_TICKS), .MAX_LEVEL(MAX_LEVEL), .RESUME_TICKS(RESUME_TICKS)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    mState = S_IDLE;  mTime = 0;     mHigh = 0;  mLives = LIVES;
    mLevel = 0;       mLevelCnt = 0; mInv = 0;   mRes = 0;
    mLane = 0;        mJumpOut = 0;  mJumpQ = 0; mPauseQ = 0;
  endtask

  // Reference behaviour for one clock edge given the currently driven inputs.
  task automatic modelStep(input bit tick, input bit died, input bit jump, input bit pause, input int lane);
    bit jr, pr, hit, tk;
    jr = jump && !mJumpQ;
    pr = pause && !mPauseQ;
    if (mState == S_PLAYING) begin
      mLane = lane;
      mJumpOut = jump;
    end else begin
      mJumpOut = 0;
    end
    case (mState)
      S_IDLE: if (jr) begin
        mState = S_PLAYING; mTime = 0; mLevel = 0; mLevelCnt = 0;
        mInv = 0; mRes = 0; mLives = LIVES;
      end
      S_PLAYING: begin
        hit = died && (mInv == 0);
        if (hit && mLives == 1) begin
          mLives = 0;
          if (mTime > mHigh) mHigh = mTime;
          mState = S_GAMEOVER;
        end else begin
          tk = tick;
          if (hit) mLives = mLives - 1;
          else if (pr) begin
            mState = S_PAUSED;
            tk = 0;
          end
          if (tk) begin
            if (mTime < SCORE_MAX) mTime = mTime + 1;
            if (mInv > 0) mInv = mInv - 1;
            if (mLevelCnt == LEVEL_TICKS - 1) begin
              mLevelCnt = 0;
              if (mLevel < MAX_LEVEL) mLevel = mLevel + 1;
            end else begin
              mLevelCnt = mLevelCnt + 1;
            end
          end
          if (hit) mInv = INVULN_TICKS;
        end
      end
      S_PAUSED: if (pr) begin
        mState = S_RESUME;
        mRes = RESUME_TICKS;
      end
      S_RESUME: begin
        if (pr) mState = S_PAUSED;
        else if (tick) begin
          mRes = mRes - 1;
          if (mRes == 0) mState = S_PLAYING;
        end
      end
      S_GAMEOVER: if (jr) mState = S_IDLE;
      default: mState = S_IDLE;
    endcase
    mJumpQ  = jump;
    mPauseQ = pause;
  endtask

  task automatic pushExpected();
    expected_t e;
    e.flags     = ((mState == S_PLAYING) ? 8 : 0) +
                  ((mState == S_PAUSED || mState == S_RESUME) ? 4 : 0) +
                  ((mState == S_GAMEOVER) ? 2 : 0) +
                  ((mState == S_IDLE) ? 1 : 0);
    e.timeAlive = mTime;
    e.highScore = mHigh;
    e.lives     = mLives;
    e.level     = mLevel;
    e.invuln    = (mInv != 0) ? 1 : 0;
    e.lane      = mLane;
    e.jumpOut   = mJumpOut ? 1 : 0;
    scoreboard.push_back(e);
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic compareOutputs(input string tag);
    expected_t e;
    int obsFlags;
    if (scoreboard.size() == 0) begin
      checkOutput({tag, ".queue"}, 0, 1);
      return;
    end
    e = scoreboard.pop_front();
    obsFlags = int'({bus.playing, bus.paused, bus.game_over, bus.reset_game});
    checkOutput({tag, ".flags"},  obsFlags,              e.flags);
    checkOutput({tag, ".time"},   int'(bus.time_alive),  e.timeAlive);
    checkOutput({tag, ".high"},   int'(bus.high_score),  e.highScore);
    checkOutput({tag, ".lives"},  int'(bus.lives_left),  e.lives);
    checkOutput({tag, ".level"},  int'(bus.level),       e.level);
    checkOutput({tag, ".invuln"}, int'(bus.invuln),      e.invuln);
    checkOutput({tag, ".lane"},   int'(bus.lane_out),    e.lane);
    checkOutput({tag, ".jump"},   int'(bus.jump_out),    e.jumpOut);
  endtask

  task automatic applyStimulus(input bit tick, input bit died, input bit jump, input bit pause,
                               input int lane, input string tag);
    bus.tick_in  = tick;
    bus.died_in  = died;
    bus.jump_in  = jump;
    bus.pause_in = pause;
    bus.lane_in  = LANE_W'(lane);
    modelStep(tick, died, jump, pause, lane);
    pushExpected();
    @(posedge clk);
    #1;
    compareOutputs(tag);
  endtask

  task automatic tickRun(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, i % 4, tag);
  endtask

  task automatic restartGame(input string tag);
    applyStimulus(0, 0, 1, 0, 0, {tag, ".to_idle"});
    applyStimulus(0, 0, 0, 0, 0, {tag, ".idle"});
    applyStimulus(0, 0, 1, 0, 0, {tag, ".start"});
    applyStimulus(0, 0, 0, 0, 0, {tag, ".release"});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.tick_in = 0; bus.died_in = 0; bus.jump_in = 0; bus.pause_in = 0; bus.lane_in = '0;
    modelReset();
    #12;
    pushExpected();
    compareOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, "idle");

    // Game 1: held jump starts once; lives, invulnerability, pause and resume.
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 0, i % 4, "start_hold");
    applyStimulus(0, 0, 0, 0, 1, "start_release");
    applyStimulus(0, 1, 0, 0, 1, "hit1");
    tickRun(4, "inv_ticks");
    applyStimulus(1, 1, 0, 0, 2, "hit2_tick");
    applyStimulus(1, 0, 0, 1, 0, "pause_tick");
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 0, 3, "paused_ticks");
    applyStimulus(0, 0, 0, 1, 0, "unpause");
    applyStimulus(1, 0, 0, 0, 0, "resume_tick");
    applyStimulus(0, 0, 0, 1, 0, "repause");
    applyStimulus(0, 0, 0, 0, 0, "paused_idle");
    applyStimulus(0, 0, 0, 1, 0, "unpause2");
    applyStimulus(1, 0, 0, 0, 0, "resume_tick1");
    applyStimulus(1, 0, 0, 0, 0, "resume_tick2");
    tickRun(2, "play_ticks");
    applyStimulus(0, 1, 0, 0, 1, "hit_during_inv");
    tickRun(2, "play_ticks2");
    applyStimulus(1, 1, 1, 0, 2, "fatal_hit");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, "held_jump_over");
    applyStimulus(0, 0, 0, 0, 0, "over_release");
    restartGame("game2");

    // Game 2: ends below the high score, which must be kept.
    applyStimulus(0, 1, 0, 0, 0, "g2_hit1");
    tickRun(4, "g2_ticks");
    applyStimulus(0, 1, 0, 0, 0, "g2_hit2");
    tickRun(4, "g2_ticks2");
    applyStimulus(0, 1, 0, 0, 0, "g2_fatal");
    restartGame("game3");

    // Game 3: a non-fatal hit outranks pause; ends above the high score.
    applyStimulus(0, 1, 0, 0, 0, "g3_hit1");
    tickRun(4, "g3_ticks");
    applyStimulus(1, 1, 0, 1, 0, "g3_hit_over_pause");
    applyStimulus(0, 0, 0, 0, 0, "g3_pause_release");
    tickRun(6, "g3_ticks2");
    applyStimulus(0, 1, 0, 0, 0, "g3_fatal");
    restartGame("game4");

    // Game 4: score and level saturation, lane/jump forwarding, then async reset.
    for (int i = 0; i < 20; i++) applyStimulus(1, 0, (i % 3) == 0, 0, (i + 1) % 4, "sat_ticks");
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    pushExpected();
    compareOutputs("async_reset");
    bus.tick_in = 0; bus.died_in = 0; bus.jump_in = 0; bus.pause_in = 0; bus.lane_in = '0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, "post_reset_idle");
    applyStimulus(0, 0, 1, 0, 2, "post_reset_start");
    applyStimulus(1, 0, 0, 0, 3, "post_reset_tick");
    applyStimulus(1, 0, 0, 0, 1, "post_reset_tick2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
